// File: rtl/biu_constants_pkg.sv
// Shared bus-interface constants: access-size encoding and its byte count.
package biu_constants_pkg;

    typedef enum logic [2:0] {
        BYTE  = 3'b000,
        HWORD = 3'b001,
        WORD  = 3'b010,
        DWORD = 3'b011
    } biu_size_t;

    // Returns 0 for encodings that name no access size.
    function automatic int biu_size2bytes(input biu_size_t size);
        case (size)
            BYTE:    return 32'sd1;
            HWORD:   return 32'sd2;
            WORD:    return 32'sd4;
            DWORD:   return 32'sd8;
            default: return 32'sd0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_memsplit_lane.sv
// Lane steering for a possibly boundary-crossing access: byte enables and write data
// over a double-width window; the low half feeds the first bus access, the high half the second.
module riscv_memsplit_lane
    import biu_constants_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int OFFW = $clog2(XLEN/8),
    localparam int BEW  = 2*XLEN/8
) (
    input  logic [OFFW-1:0]   i_off,
    input  biu_size_t         i_size,
    input  logic [XLEN-1:0]   i_d,
    output logic [BEW-1:0]    o_be,
    output logic [2*XLEN-1:0] o_wd
);

    logic [BEW-1:0] w_mask;

    // Unshifted byte mask, one bit per byte of the access.
    always_comb begin
        w_mask = '0;
        case (i_size)
            BYTE:    w_mask[0]   = 1'b1;
            HWORD:   w_mask[1:0] = 2'b11;
            WORD:    w_mask[3:0] = 4'hF;
            DWORD:   w_mask[7:0] = 8'hFF;
            default: w_mask      = '0;
        endcase
    end

    assign o_be = w_mask << i_off;
    assign o_wd = {{XLEN{1'b0}}, i_d} << {i_off, 3'b000};

endmodule

// File: rtl/riscv_memsplit.sv
// Splits one LSU load/store into one or two aligned BIU accesses and merges the
// read data back into a single right-justified result.
module riscv_memsplit
    import biu_constants_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic [PLEN-1:0]   adr_i,
    input  biu_size_t         size_i,
    input  logic              we_i,
    input  logic [XLEN-1:0]   d_i,
    output logic              busy_o,
    output logic              ack_o,
    output logic              err_o,
    output logic [XLEN-1:0]   q_o,
    output logic              mem_req_o,
    output logic [PLEN-1:0]   mem_adr_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_d_o,
    input  logic              mem_ack_i,
    input  logic              mem_err_i,
    input  logic [XLEN-1:0]   mem_q_i
);

    localparam int BYTES = XLEN/8;
    localparam int OFFW  = $clog2(BYTES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FIRST  = 3'd1,
        S_SECOND = 3'd2,
        S_DONE   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    state_t            r_state;
    logic [OFFW-1:0]   r_off;
    biu_size_t         r_size;
    logic              r_cross;
    logic [BYTES-1:0]  r_be_hi;
    logic [XLEN-1:0]   r_wd_hi;
    logic [XLEN-1:0]   r_q0;
    logic              r_ack;
    logic              r_err;
    logic [XLEN-1:0]   r_q;
    logic              r_mem_req;
    logic [PLEN-1:0]   r_mem_adr;
    logic              r_mem_we;
    logic [BYTES-1:0]  r_mem_be;
    logic [XLEN-1:0]   r_mem_d;

    state_t            w_state_nxt;
    logic [OFFW-1:0]   w_off;
    logic [2*BYTES-1:0] w_be;
    logic [2*XLEN-1:0] w_wd;
    int                w_nbytes;
    logic              w_legal;
    logic              w_cross;
    logic              w_accept;
    logic              w_ack_nxt;
    logic              w_err_nxt;
    logic [XLEN-1:0]   w_q_nxt;
    logic              w_mem_req_nxt;
    logic [PLEN-1:0]   w_mem_adr_nxt;
    logic              w_mem_we_nxt;
    logic [BYTES-1:0]  w_mem_be_nxt;
    logic [XLEN-1:0]   w_mem_d_nxt;

    // Shift the two captured words down to the access offset and zero-fill above the size.
    function automatic logic [XLEN-1:0] merge_q(input logic [XLEN-1:0] q1, input logic [XLEN-1:0] q0,
                                                input logic [OFFW-1:0] off, input biu_size_t size);
        logic [XLEN-1:0] mask;
        case (size)
            BYTE:    mask = XLEN'(8'hFF);
            HWORD:   mask = XLEN'(16'hFFFF);
            WORD:    mask = XLEN'(32'hFFFF_FFFF);
            DWORD:   mask = '1;
            default: mask = '0;
        endcase
        return XLEN'({q1, q0} >> {off, 3'b000}) & mask;
    endfunction

    assign w_off    = adr_i[OFFW-1:0];
    assign w_nbytes = biu_size2bytes(size_i);
    assign w_legal  = (w_nbytes != 32'sd0) && (w_nbytes <= BYTES);
    assign w_cross  = (int'(w_off) + w_nbytes) > BYTES;
    assign w_accept = (r_state == S_IDLE) && req_i && w_legal;

    riscv_memsplit_lane #(.XLEN(XLEN)) u_lane (
        .i_off  (w_off),
        .i_size (size_i),
        .i_d    (d_i),
        .o_be   (w_be),
        .o_wd   (w_wd)
    );

    // Next-state and next-output decode; bus outputs drop to zero whenever no access is pending.
    always_comb begin
        w_state_nxt   = r_state;
        w_ack_nxt     = 1'b0;
        w_err_nxt     = 1'b0;
        w_q_nxt       = '0;
        w_mem_req_nxt = 1'b0;
        w_mem_adr_nxt = '0;
        w_mem_we_nxt  = 1'b0;
        w_mem_be_nxt  = '0;
        w_mem_d_nxt   = '0;
        case (r_state)
            S_IDLE: begin
                if (req_i && w_legal) begin
                    w_state_nxt   = S_FIRST;
                    w_mem_req_nxt = 1'b1;
                    w_mem_adr_nxt = {adr_i[PLEN-1:OFFW], {OFFW{1'b0}}};
                    w_mem_we_nxt  = we_i;
                    w_mem_be_nxt  = w_be[BYTES-1:0];
                    w_mem_d_nxt   = w_wd[XLEN-1:0];
                end else if (req_i) begin
                    w_state_nxt = S_ERR;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FIRST: begin
                if (mem_err_i) begin
                    w_state_nxt = S_ERR;
                    w_err_nxt   = 1'b1;
                end else if (mem_ack_i && r_cross) begin
                    // Second access follows with no idle gap; address wraps modulo 2^PLEN.
                    w_state_nxt   = S_SECOND;
                    w_mem_req_nxt = 1'b1;
                    w_mem_adr_nxt = r_mem_adr + PLEN'(BYTES);
                    w_mem_we_nxt  = r_mem_we;
                    w_mem_be_nxt  = r_be_hi;
                    w_mem_d_nxt   = r_wd_hi;
                end else if (mem_ack_i) begin
                    w_state_nxt = S_DONE;
                    w_ack_nxt   = 1'b1;
                    w_q_nxt     = r_mem_we ? '0 : merge_q({XLEN{1'b0}}, mem_q_i, r_off, r_size);
                end else begin
                    w_mem_req_nxt = 1'b1;
                    w_mem_adr_nxt = r_mem_adr;
                    w_mem_we_nxt  = r_mem_we;
                    w_mem_be_nxt  = r_mem_be;
                    w_mem_d_nxt   = r_mem_d;
                end
            end
            S_SECOND: begin
                if (mem_err_i) begin
                    w_state_nxt = S_ERR;
                    w_err_nxt   = 1'b1;
                end else if (mem_ack_i) begin
                    w_state_nxt = S_DONE;
                    w_ack_nxt   = 1'b1;
                    w_q_nxt     = r_mem_we ? '0 : merge_q(mem_q_i, r_q0, r_off, r_size);
                end else begin
                    w_mem_req_nxt = 1'b1;
                    w_mem_adr_nxt = r_mem_adr;
                    w_mem_we_nxt  = r_mem_we;
                    w_mem_be_nxt  = r_mem_be;
                    w_mem_d_nxt   = r_mem_d;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, registered outputs, request context and first-word capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_off     <= '0;
            r_size    <= BYTE;
            r_cross   <= 1'b0;
            r_be_hi   <= '0;
            r_wd_hi   <= '0;
            r_q0      <= '0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_q       <= '0;
            r_mem_req <= 1'b0;
            r_mem_adr <= '0;
            r_mem_we  <= 1'b0;
            r_mem_be  <= '0;
            r_mem_d   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ack     <= w_ack_nxt;
            r_err     <= w_err_nxt;
            r_q       <= w_q_nxt;
            r_mem_req <= w_mem_req_nxt;
            r_mem_adr <= w_mem_adr_nxt;
            r_mem_we  <= w_mem_we_nxt;
            r_mem_be  <= w_mem_be_nxt;
            r_mem_d   <= w_mem_d_nxt;
            if (w_accept) begin
                r_off   <= w_off;
                r_size  <= size_i;
                r_cross <= w_cross;
                r_be_hi <= w_be[2*BYTES-1:BYTES];
                r_wd_hi <= w_wd[2*XLEN-1:XLEN];
            end
            if ((r_state == S_FIRST) && mem_ack_i && !mem_err_i) begin
                r_q0 <= mem_q_i;
            end
        end
    end

    assign busy_o    = (r_state != S_IDLE);
    assign ack_o     = r_ack;
    assign err_o     = r_err;
    assign q_o       = r_q;
    assign mem_req_o = r_mem_req;
    assign mem_adr_o = r_mem_adr;
    assign mem_we_o  = r_mem_we;
    assign mem_be_o  = r_mem_be;
    assign mem_d_o   = r_mem_d;

endmodule

// File: tb/tb_riscv_memsplit.sv
// Directed bench for riscv_memsplit at XLEN=32 with a hand-driven bus.
module tb_riscv_memsplit;
    import biu_constants_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic [31:0] adr_i;
    biu_size_t   size_i;
    logic        we_i;
    logic [31:0] d_i;
    logic        busy_o, ack_o, err_o;
    logic [31:0] q_o;
    logic        mem_req_o;
    logic [31:0] mem_adr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_d_o;
    logic        mem_ack_i, mem_err_i;
    logic [31:0] mem_q_i;

    int checks   = 0;
    int failures = 0;

    // {busy, ack, err, mem_req, mem_we, mem_be, mem_adr, mem_d, q}
    logic [104:0] obs;
    logic [104:0] exp_v;
    assign obs = {busy_o, ack_o, err_o, mem_req_o, mem_we_o, mem_be_o, mem_adr_o, mem_d_o, q_o};

    riscv_memsplit #(.XLEN(32), .PLEN(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .adr_i(adr_i), .size_i(size_i),
        .we_i(we_i), .d_i(d_i), .busy_o(busy_o), .ack_o(ack_o), .err_o(err_o), .q_o(q_o),
        .mem_req_o(mem_req_o), .mem_adr_o(mem_adr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_d_o(mem_d_o), .mem_ack_i(mem_ack_i), .mem_err_i(mem_err_i), .mem_q_i(mem_q_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [31:0] adr, input biu_size_t size, input logic we, input logic [31:0] d);
        req_i = 1'b1; adr_i = adr; size_i = size; we_i = we; d_i = d;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_i = 1'b0; adr_i = '0; size_i = BYTE; we_i = 1'b0; d_i = '0;
        mem_ack_i = 1'b0; mem_err_i = 1'b0; mem_q_i = '0;
        tick(); tick();
        exp_v = '0; checks++; if (obs !== exp_v) begin failures++; $display("FAIL reset_held got=%h exp=%h", obs, exp_v); end
        rst_i = 1'b0;
        tick();
        exp_v = '0; checks++; if (obs !== exp_v) begin failures++; $display("FAIL reset_release got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_load_cross();
        issue(32'h0000_1002, WORD, 1'b0, 32'h0);
        tick(); req_i = 1'b0;
        exp_v = {5'b10010, 4'b1100, 32'h0000_1000, 32'h0, 32'h0};
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL ldx_first got=%h exp=%h", obs, exp_v); end
        mem_ack_i = 1'b1; mem_q_i = 32'hAABB_CCDD;
        tick();
        exp_v = {5'b10010, 4'b0011, 32'h0000_1004, 32'h0, 32'h0};
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL ldx_second got=%h exp=%h", obs, exp_v); end
        mem_q_i = 32'h1122_3344;
        tick(); mem_ack_i = 1'b0; mem_q_i = '0;
        exp_v = {5'b11000, 4'b0000, 32'h0, 32'h0, 32'h3344_AABB};
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL ldx_ack got=%h exp=%h", obs, exp_v); end
        tick();
        exp_v = '0; checks++; if (obs !== exp_v) begin failures++; $display("FAIL ldx_idle got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_store_cross();
        issue(32'h0000_1003, WORD, 1'b1, 32'h1122_3344);
        tick(); req_i = 1'b0; d_i = '0;
        exp_v = {5'b10011, 4'b1000, 32'h0000_1000, 32'h4400_0000, 32'h0};
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL stx_first got=%h exp=%h", obs, exp_v); end
        mem_ack_i = 1'b1;
        tick();
        exp_v = {5'b10011, 4'b0111, 32'h0000_1004, 32'h0011_2233, 32'h0};
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL stx_second got=%h exp=%h", obs, exp_v); end
        tick(); mem_ack_i = 1'b0;
        exp_v = {5'b11000, 4'b0000, 32'h0, 32'h0, 32'h0};
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL stx_ack got=%h exp=%h", obs, exp_v); end
        tick();
        exp_v = '0; checks++; if (obs !== exp_v) begin failures++; $display("FAIL stx_idle got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_load_single();
        issue(32'h0000_2002, HWORD, 1'b0, 32'h0);
        tick(); req_i = 1'b0;
        exp_v = {5'b10010, 4'b1100, 32'h0000_2000, 32'h0, 32'h0};
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL lds_req got=%h exp=%h", obs, exp_v); end
        mem_ack_i = 1'b1; mem_q_i = 32'hBEEF_1234;
        tick(); mem_ack_i = 1'b0; mem_q_i = '0;
        exp_v = {5'b11000, 4'b0000, 32'h0, 32'h0, 32'h0000_BEEF};
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL lds_ack got=%h exp=%h", obs, exp_v); end
        tick();
        exp_v = '0; checks++; if (obs !== exp_v) begin failures++; $display("FAIL lds_idle got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_err_first();
        issue(32'h0000_1002, WORD, 1'b0, 32'h0);
        tick(); req_i = 1'b0;
        exp_v = {5'b10010, 4'b1100, 32'h0000_1000, 32'h0, 32'h0};
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL err_req got=%h exp=%h", obs, exp_v); end
        mem_err_i = 1'b1; mem_ack_i = 1'b1; mem_q_i = 32'hDEAD_BEEF;
        tick(); mem_err_i = 1'b0; mem_ack_i = 1'b0; mem_q_i = '0;
        exp_v = {5'b10100, 4'b0000, 32'h0, 32'h0, 32'h0};
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL err_pulse got=%h exp=%h", obs, exp_v); end
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_v = '0; checks++; if (obs !== exp_v) begin failures++; $display("FAIL err_after%0d got=%h exp=%h", i, obs, exp_v); end
        end
    endtask

    task automatic test_reset_in_second();
        issue(32'h0000_1002, WORD, 1'b0, 32'h0);
        tick(); req_i = 1'b0;
        mem_ack_i = 1'b1; mem_q_i = 32'hAABB_CCDD;
        tick(); mem_ack_i = 1'b0; mem_q_i = '0;
        exp_v = {5'b10010, 4'b0011, 32'h0000_1004, 32'h0, 32'h0};
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL rst2_second got=%h exp=%h", obs, exp_v); end
        rst_i = 1'b1;
        tick(); rst_i = 1'b0;
        exp_v = '0; checks++; if (obs !== exp_v) begin failures++; $display("FAIL rst2_cleared got=%h exp=%h", obs, exp_v); end
        issue(32'h0000_3001, BYTE, 1'b0, 32'h0);
        tick(); req_i = 1'b0;
        exp_v = {5'b10010, 4'b0010, 32'h0000_3000, 32'h0, 32'h0};
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL rst2_fresh_req got=%h exp=%h", obs, exp_v); end
        mem_ack_i = 1'b1; mem_q_i = 32'h5566_7788;
        tick(); mem_ack_i = 1'b0; mem_q_i = '0;
        exp_v = {5'b11000, 4'b0000, 32'h0, 32'h0, 32'h0000_0077};
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL rst2_fresh_ack got=%h exp=%h", obs, exp_v); end
        tick();
    endtask

    task automatic test_back_to_back();
        issue(32'h0000_4003, HWORD, 1'b0, 32'h0);
        tick();
        issue(32'h0000_5001, WORD, 1'b0, 32'h0);
        exp_v = {5'b10010, 4'b1000, 32'h0000_4000, 32'h0, 32'h0};
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL b2b_a_first got=%h exp=%h", obs, exp_v); end
        mem_ack_i = 1'b1; mem_q_i = 32'h1234_5678;
        tick();
        exp_v = {5'b10010, 4'b0001, 32'h0000_4004, 32'h0, 32'h0};
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL b2b_a_second got=%h exp=%h", obs, exp_v); end
        mem_q_i = 32'h9ABC_DEF0;
        tick(); mem_ack_i = 1'b0; mem_q_i = '0;
        exp_v = {5'b11000, 4'b0000, 32'h0, 32'h0, 32'h0000_F012};
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL b2b_a_ack got=%h exp=%h", obs, exp_v); end
        tick();
        exp_v = '0; checks++; if (obs !== exp_v) begin failures++; $display("FAIL b2b_gap got=%h exp=%h", obs, exp_v); end
        tick(); req_i = 1'b0;
        exp_v = {5'b10010, 4'b1110, 32'h0000_5000, 32'h0, 32'h0};
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL b2b_b_first got=%h exp=%h", obs, exp_v); end
        mem_ack_i = 1'b1; mem_q_i = 32'hDDCC_BBAA;
        tick();
        exp_v = {5'b10010, 4'b0001, 32'h0000_5004, 32'h0, 32'h0};
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL b2b_b_second got=%h exp=%h", obs, exp_v); end
        mem_q_i = 32'h4433_2211;
        tick(); mem_ack_i = 1'b0; mem_q_i = '0;
        exp_v = {5'b11000, 4'b0000, 32'h0, 32'h0, 32'h11DD_CCBB};
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL b2b_b_ack got=%h exp=%h", obs, exp_v); end
        tick();
    endtask

    task automatic test_illegal_size();
        biu_size_t bad [2];
        bad[0] = DWORD;
        bad[1] = biu_size_t'(3'b111);
        for (int i = 0; i < 2; i++) begin
            issue(32'h0000_6000, bad[i], 1'b0, 32'h0);
            tick(); req_i = 1'b0;
            exp_v = {5'b10100, 4'b0000, 32'h0, 32'h0, 32'h0};
            checks++; if (obs !== exp_v) begin failures++; $display("FAIL illegal%0d_err got=%h exp=%h", i, obs, exp_v); end
            tick();
            exp_v = '0; checks++; if (obs !== exp_v) begin failures++; $display("FAIL illegal%0d_idle got=%h exp=%h", i, obs, exp_v); end
        end
    endtask

    task automatic test_wrap_wait();
        issue(32'hFFFF_FFFE, WORD, 1'b0, 32'h0);
        tick(); req_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_v = {5'b10010, 4'b1100, 32'hFFFF_FFFC, 32'h0, 32'h0};
            checks++; if (obs !== exp_v) begin failures++; $display("FAIL wrap_first%0d got=%h exp=%h", i, obs, exp_v); end
            if (i == 1) begin
                mem_ack_i = 1'b1; mem_q_i = 32'h3333_2222;
            end
            tick();
        end
        exp_v = {5'b10010, 4'b0011, 32'h0000_0000, 32'h0, 32'h0};
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL wrap_second got=%h exp=%h", obs, exp_v); end
        mem_q_i = 32'h5555_4444;
        tick(); mem_ack_i = 1'b0; mem_q_i = '0;
        exp_v = {5'b11000, 4'b0000, 32'h0, 32'h0, 32'h4444_3333};
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL wrap_ack got=%h exp=%h", obs, exp_v); end
        tick();
        exp_v = '0; checks++; if (obs !== exp_v) begin failures++; $display("FAIL wrap_idle got=%h exp=%h", obs, exp_v); end
    endtask

    initial begin
        test_reset();
        test_load_cross();
        test_store_cross();
        test_load_single();
        test_err_first();
        test_reset_in_second();
        test_back_to_back();
        test_illegal_size();
        test_wrap_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
